// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: datapath width, reset PC, bubble encoding and
// the fetch-stage state encoding.
package riscv_pkg;

    localparam int                XLEN      = 32;
    localparam logic [XLEN-1:0]   RESET_PC  = 32'h0000_0000;
    localparam logic [31:0]       NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    typedef enum logic [1:0] {
        REQ  = 2'b00,
        WAIT = 2'b01,
        KILL = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush, stall        hazard controls (flush wins over stall)
//   load                a fetched instruction is offered this cycle
//   load_instr/pc/pc_plus4  offered instruction fields
//   instr_d, pc_d, pc_plus4_d, valid_d  register contents
// Priority: reset > flush > stall > load > bubble.
module if_id_register
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [31:0]     load_instr,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_pc_plus4,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
);

    // PC fields are left untouched on flush/bubble; they are meaningless
    // whenever valid_d is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (flush) begin
            instr_d    <= NOP_INSTR;
            valid_d    <= 1'b0;
        end else if (stall) begin
            // hold
        end else if (load) begin
            instr_d    <= load_instr;
            pc_d       <= load_pc;
            pc_plus4_d <= load_pc_plus4;
            valid_d    <= 1'b1;
        end else begin
            instr_d    <= NOP_INSTR;
            valid_d    <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: PC, one-outstanding-request imem FSM,
// 1-entry hold buffer for responses that land while decode is stalled,
// and the IF/ID register.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   stall_f, stall_d, flush_d  hazard-unit controls
//   pc_src_e, pc_target_e      execute-stage redirect
//   imem_req_valid/ready/addr  instruction memory request channel
//   imem_resp_valid/data       instruction memory response channel
//   instr_d, pc_d, pc_plus4_d, valid_d  IF/ID outputs
//
// state | meaning
// REQ   | nothing outstanding, issue when allowed
// WAIT  | one request outstanding, its response is wanted
// KILL  | one request outstanding, its response is wrong-path
module fetch_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] req_pc;
    logic            hold_valid;
    logic [31:0]     hold_instr;
    logic [XLEN-1:0] hold_pc;

    logic            accept;
    logic            deliver;
    logic            load;
    logic [31:0]     load_instr;
    logic [XLEN-1:0] load_pc;

    assign imem_req_addr = pc_f;

    // A response may be followed by a new request in the same cycle, which
    // gives one instruction per cycle when memory answers in one cycle.
    always_comb begin
        imem_req_valid = !reset && !stall_f && !pc_src_e && !hold_valid &&
                         ((state == REQ) || ((state == WAIT) && imem_resp_valid));
    end

    assign accept  = imem_req_valid && imem_req_ready;
    assign deliver = (state == WAIT) && imem_resp_valid && !pc_src_e;

    always_comb begin
        state_nxt = state;
        case (state)
            REQ: begin
                if (!pc_src_e && accept) state_nxt = WAIT;
            end
            WAIT: begin
                if (pc_src_e)             state_nxt = imem_resp_valid ? REQ : KILL;
                else if (imem_resp_valid) state_nxt = accept ? WAIT : REQ;
            end
            KILL: begin
                // A response arriving here is always the wrong-path one, even
                // if another redirect lands in the same cycle.
                if (imem_resp_valid) state_nxt = REQ;
            end
            default: state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= REQ;
            pc_f   <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (pc_src_e) begin
                pc_f <= pc_target_e;
            end else if (accept) begin
                pc_f   <= pc_f + XLEN'(4);
                req_pc <= pc_f;
            end
        end
    end

    // The hazard unit raises stall_f whenever stall_d is high, so no second
    // response can arrive while the buffer is occupied.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc    <= '0;
        end else if (pc_src_e) begin
            hold_valid <= 1'b0;
        end else if (deliver && stall_d) begin
            hold_valid <= 1'b1;
            hold_instr <= imem_resp_data;
            hold_pc    <= req_pc;
        end else if (hold_valid && !stall_d) begin
            hold_valid <= 1'b0;
        end
    end

    assign load       = hold_valid || deliver;
    assign load_instr = hold_valid ? hold_instr : imem_resp_data;
    assign load_pc    = hold_valid ? hold_pc    : req_pc;

    if_id_register u_if_id (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush_d),
        .stall         (stall_d),
        .load          (load),
        .load_instr    (load_instr),
        .load_pc       (load_pc),
        .load_pc_plus4 (load_pc + XLEN'(4)),
        .instr_d       (instr_d),
        .pc_d          (pc_d),
        .pc_plus4_d    (pc_plus4_d),
        .valid_d       (valid_d)
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        valid_d;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall_f         (stall_f),
        .stall_d         (stall_d),
        .flush_d         (flush_d),
        .pc_src_e        (pc_src_e),
        .pc_target_e     (pc_target_e),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_d         (instr_d),
        .pc_d            (pc_d),
        .pc_plus4_d      (pc_plus4_d),
        .valid_d         (valid_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; registered outputs are stable 1 time unit later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Let newly driven inputs settle before checking combinational outputs.
    task automatic settle;
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ipc,
                            input logic [31:0] iins, input logic ivld);
        chk({tag, ".pc_d"},       pc_d,       ipc);
        chk({tag, ".pc_plus4_d"}, pc_plus4_d, ipc + 32'd4);
        chk({tag, ".instr_d"},    instr_d,    iins);
        chk({tag, ".valid_d"},    {31'd0, valid_d}, {31'd0, ivld});
    endtask

    task automatic chk_req(input string tag, input logic vld, input logic [31:0] addr);
        chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, vld});
        chk({tag, ".req_addr"},  imem_req_addr, addr);
    endtask

    initial begin
        reset = 1'b1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0;
        pc_target_e = 0; imem_req_ready = 1; imem_resp_valid = 0; imem_resp_data = 0;

        tick; tick;
        chk("rst.req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst.instr_d",   instr_d, NOP);
        chk("rst.pc_d",      pc_d, 32'd0);
        chk("rst.pc_plus4",  pc_plus4_d, 32'd0);
        chk("rst.valid_d",   {31'd0, valid_d}, 32'd0);
        chk("rst.addr",      imem_req_addr, 32'd0);

        // Back-to-back fetch with 1-cycle response latency
        reset = 0; settle;
        chk_req("seq0", 1, 32'h0);
        tick;
        imem_resp_valid = 1; imem_resp_data = 32'hA000_0000; settle;
        chk_req("seq1", 1, 32'h4);
        tick;
        chk_ifid("seq1.d", 32'h0, 32'hA000_0000, 1);
        imem_resp_data = 32'hA000_0004; settle;
        chk_req("seq2", 1, 32'h8);
        tick;
        chk_ifid("seq2.d", 32'h4, 32'hA000_0004, 1);
        imem_resp_data = 32'hA000_0008; settle;
        chk_req("seq3", 1, 32'hC);
        tick;
        chk_ifid("seq3.d", 32'h8, 32'hA000_0008, 1);

        // Stall both stages while the response for 0xC arrives
        stall_f = 1; stall_d = 1; imem_resp_data = 32'hA000_000C; settle;
        chk_req("stall0", 0, 32'h10);
        tick;
        chk_ifid("stall0.d", 32'h8, 32'hA000_0008, 1);
        imem_resp_valid = 0; settle;
        for (int i = 0; i < 2; i++) begin
            chk_req("stallN", 0, 32'h10);
            tick;
            chk_ifid("stallN.d", 32'h8, 32'hA000_0008, 1);
        end
        stall_f = 0; stall_d = 0; settle;
        chk_req("unstall", 0, 32'h10);
        tick;
        chk_ifid("unstall.d", 32'hC, 32'hA000_000C, 1);
        settle;
        chk_req("after_buf", 1, 32'h10);
        tick;
        chk("bubble.valid_d", {31'd0, valid_d}, 32'd0);
        chk("bubble.instr_d", instr_d, NOP);

        // Redirect while WAIT, wrong-path response 2 cycles later
        pc_src_e = 1; pc_target_e = 32'h100; settle;
        chk_req("redir0", 0, 32'h14);
        tick;
        pc_src_e = 0; settle;
        chk_req("kill0", 0, 32'h100);
        tick;
        imem_resp_valid = 1; imem_resp_data = 32'hDEAD_BEEF; settle;
        chk_req("kill1", 0, 32'h100);
        tick;
        chk("kill.valid_d", {31'd0, valid_d}, 32'd0);
        chk("kill.instr_d", instr_d, NOP);
        imem_resp_valid = 0; settle;
        chk_req("tgt", 1, 32'h100);
        tick;

        // Redirect in the same cycle as the response
        imem_resp_valid = 1; imem_resp_data = 32'hA000_0100;
        pc_src_e = 1; pc_target_e = 32'h200; settle;
        chk_req("redir_resp", 0, 32'h104);
        tick;
        chk("redir_resp.valid_d", {31'd0, valid_d}, 32'd0);
        imem_resp_valid = 0; pc_src_e = 0; settle;
        chk_req("tgt2", 1, 32'h200);
        tick;

        // Deliver 0x200 while memory refuses the next request, then 4 stalled cycles
        imem_resp_valid = 1; imem_resp_data = 32'hA000_0200; imem_req_ready = 0; settle;
        chk_req("nrdy0", 1, 32'h204);
        tick;
        chk_ifid("nrdy0.d", 32'h200, 32'hA000_0200, 1);
        imem_resp_valid = 0; settle;
        for (int i = 0; i < 4; i++) begin
            chk_req("nrdyN", 1, 32'h204);
            tick;
            chk("nrdyN.valid_d", {31'd0, valid_d}, 32'd0);
        end
        imem_req_ready = 1; settle;
        chk_req("rdy", 1, 32'h204);
        tick;
        chk("rdy.addr", imem_req_addr, 32'h208);

        // Deliver 0x204 with fetch stalled, then flush together with stall_d
        stall_f = 1; imem_resp_valid = 1; imem_resp_data = 32'hA000_0204; settle;
        chk_req("sf", 0, 32'h208);
        tick;
        chk_ifid("sf.d", 32'h204, 32'hA000_0204, 1);
        imem_resp_valid = 0; flush_d = 1; stall_d = 1;
        tick;
        chk("flush.instr_d", instr_d, NOP);
        chk("flush.valid_d", {31'd0, valid_d}, 32'd0);
        flush_d = 0; stall_d = 0; stall_f = 0;

        // PC wrap at top of address space
        pc_src_e = 1; pc_target_e = 32'hFFFF_FFFC;
        tick;
        pc_src_e = 0; settle;
        chk_req("wrap0", 1, 32'hFFFF_FFFC);
        tick;
        chk_req("wrap1", 0, 32'h0);
        imem_resp_valid = 1; imem_resp_data = 32'hA0FF_FFFC; settle;
        chk_req("wrap2", 1, 32'h0);
        tick;
        chk("wrap.pc_d",     pc_d,       32'hFFFF_FFFC);
        chk("wrap.pc_plus4", pc_plus4_d, 32'h0);
        chk("wrap.instr_d",  instr_d,    32'hA0FF_FFFC);
        imem_resp_valid = 0;

        // Reset mid-WAIT returns everything to reset values
        reset = 1;
        tick;
        chk("rst2.valid_d", {31'd0, valid_d}, 32'd0);
        chk("rst2.addr", imem_req_addr, 32'h0);
        chk("rst2.req_valid", {31'd0, imem_req_valid}, 32'd0);
        reset = 0; settle;
        chk_req("rst2.req", 1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
